// File: rtl/mem_cmd_issuer.sv
// Host-side initiator for the byte-oriented UART memory protocol.
// Serializes one read/write request into the TX FIFO (cmd, addr[, data]).
// For reads it then collects the single response byte from the RX FIFO.
module mem_cmd_issuer #(
    parameter int unsigned              FIFO_WIDTH     = 8,
    parameter int unsigned              TIMEOUT_CYCLES = 1000000,
    parameter logic [FIFO_WIDTH-1:0]    CMD_READ       = 'h30,
    parameter logic [FIFO_WIDTH-1:0]    CMD_WRITE      = 'h31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [FIFO_WIDTH-1:0] req_addr,
    input  logic [FIFO_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [FIFO_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    input  logic                  tx_fifo_full,
    output logic                  tx_fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] tx_fifo_din,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] rx_fifo_dout,
    output logic [5:0]            state_leds
);

    // A zero timeout disables the counter, so keep at least one bit to stay legal.
    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_ADDR = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_RESP = 3'd4,
        CAPTURE   = 3'd5,
        RESP      = 3'd6
    } state_e;

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [FIFO_WIDTH-1:0]   addr_q, addr_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic [FIFO_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    req_ready_c;
    logic                    tx_wr_c;
    logic [FIFO_WIDTH-1:0]   tx_din_c;
    logic                    rx_rd_c;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state, FIFO strobes and request handshake.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        req_ready_c = 1'b0;
        tx_wr_c     = 1'b0;
        tx_din_c    = '0;
        rx_rd_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_fifo_empty) begin
                    rx_rd_c = 1'b1;
                end else begin
                    req_ready_c = 1'b1;
                    if (req_valid) begin
                        write_d = req_write;
                        addr_d  = req_addr;
                        data_d  = req_data;
                        state_d = SEND_CMD;
                    end
                end
            end
            SEND_CMD: begin
                if (!tx_fifo_full) begin
                    tx_wr_c  = 1'b1;
                    tx_din_c = write_q ? CMD_WRITE : CMD_READ;
                    state_d  = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                if (!tx_fifo_full) begin
                    tx_wr_c  = 1'b1;
                    tx_din_c = addr_q;
                    cnt_d    = '0;
                    state_d  = write_q ? SEND_DATA : WAIT_RESP;
                end
            end
            SEND_DATA: begin
                if (!tx_fifo_full) begin
                    tx_wr_c  = 1'b1;
                    tx_din_c = data_q;
                    state_d  = IDLE;
                end
            end
            WAIT_RESP: begin
                if (!rx_fifo_empty) begin
                    rx_rd_c = 1'b1;
                    state_d = CAPTURE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    state_d     = RESP;
                end
            end
            CAPTURE: begin
                resp_data_d = rx_fifo_dout;
                resp_err_d  = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign req_ready     = !rst && req_ready_c;
    assign tx_fifo_wr_en = !rst && tx_wr_c;
    assign tx_fifo_din   = rst ? '0 : tx_din_c;
    assign rx_fifo_rd_en = !rst && rx_rd_c;
    assign resp_valid    = !rst && (state_q == RESP);
    assign resp_data     = rst ? '0 : resp_data_q;
    assign resp_err      = !rst && resp_err_q;
    assign state_leds    = rst ? 6'd0 : {3'b000, state_q};

endmodule

// File: doc/mem_cmd_issuer.md
Name: mem_cmd_issuer

Overview:
- Host-side initiator for the byte-oriented UART memory protocol.
- Accepts one read or write request at a time on a valid/ready interface and serializes it into a TX FIFO as bytes: cmd, addr, and data for writes.
- For reads, pulls the single response byte from an RX FIFO and presents it on a valid/ready response port.
- Sits between a test/sequencer block and the UART FIFOs, opposite the on-board memory controller.

Parameters:
FIFO_WIDTH, 8, byte width of FIFO data and request/response fields.
TIMEOUT_CYCLES, 1000000, cycles to wait in WAIT_RESP for a read response before flagging an error; 0 disables the timeout.
CMD_READ, 8'h30, command byte for a read (ASCII '0').
CMD_WRITE, 8'h31, command byte for a write (ASCII '1').

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  issuer can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  FIFO_WIDTH  memory address
req_data  input  FIFO_WIDTH  write data; ignored for reads
resp_valid  output  1  read response held valid
resp_ready  input  1  consumer accepts response
resp_data  output  FIFO_WIDTH  read data; 0 on error
resp_err  output  1  response produced by timeout
tx_fifo_full  input  1  TX FIFO full
tx_fifo_wr_en  output  1  TX FIFO write strobe
tx_fifo_din  output  FIFO_WIDTH  byte written to TX FIFO
rx_fifo_empty  input  1  RX FIFO empty
rx_fifo_rd_en  output  1  RX FIFO read strobe
rx_fifo_dout  input  FIFO_WIDTH  RX FIFO data, valid the cycle after rd_en
state_leds  output  6  {3'b000, state}

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. While `rst` is high, all of the following are 0 and the next state is IDLE: state, resp_valid, resp_err, resp_data, tx_fifo_wr_en, rx_fifo_rd_en, req_ready.
- State encoding (3 bits):
  - IDLE=0, SEND_CMD=1, SEND_ADDR=2, SEND_DATA=3, WAIT_RESP=4, CAPTURE=5, RESP=6.
- IDLE:
  - If !rx_fifo_empty: rx_fifo_rd_en=1, req_ready=0, and the byte is discarded (drains stray or late bytes).
  - Otherwise req_ready=1. On req_valid&&req_ready: latch write/addr/data, go to SEND_CMD.
- SEND_CMD:
  - tx_fifo_din = CMD_WRITE or CMD_READ.
  - tx_fifo_wr_en = !tx_fifo_full. Advance to SEND_ADDR only when written; stall while full.
- SEND_ADDR:
  - tx_fifo_din = addr, wr_en = !full.
  - When written, go to SEND_DATA for writes or WAIT_RESP for reads.
- SEND_DATA:
  - tx_fifo_din = data, wr_en = !full. When written, go to IDLE.
  - Writes produce no response.
- WAIT_RESP:
  - The timeout counter clears on entry and increments each cycle.
  - If !rx_fifo_empty: rx_fifo_rd_en=1, go to CAPTURE.
  - Else if TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1: resp_err<=1, resp_data<=0, go to RESP.
  - Data available wins over timeout in the same cycle.
- CAPTURE: resp_data<=rx_fifo_dout, resp_err<=0, go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable.
  - On resp_ready, go to IDLE.
  - req_ready=0 and no FIFO strobes.
- Strobe rules:
  - tx_fifo_wr_en is never asserted while tx_fifo_full=1.
  - rx_fifo_rd_en is never asserted while rx_fifo_empty=1.
  - At most one byte moves per cycle per FIFO.
  - tx_fifo_din = 0 whenever wr_en=0.
- Latency with FIFOs never full:
  - Write: request accept to last byte written = 3 cycles.
  - Read: request accept to resp_valid = 3 cycles plus response wait plus 2.
- Reset mid-transaction abandons it; partially sent bytes are not retracted.
- The timeout counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.

Test Plan:
1. Write addr=8'h12, data=8'hA5, FIFOs idle -> TX bytes 31,12,A5 on three consecutive cycles; no resp_valid; req_ready high again in cycle 4.
2. Read addr=8'h40; RX FIFO supplies 8'h7E 10 cycles later -> TX bytes 30,40; one rx_fifo_rd_en; resp_valid with resp_data=7E, resp_err=0; held until resp_ready.
3. tx_fifo_full held high for 5 cycles during SEND_ADDR of a write -> no wr_en while full; the 12 byte is written the cycle full drops; byte order unchanged.
4. Read with TIMEOUT_CYCLES=16 and no response -> resp_valid with resp_err=1, resp_data=0 exactly 16 cycles after entering WAIT_RESP. A late byte arriving afterwards is drained in IDLE before the next req_ready=1.
5. rst pulsed in SEND_DATA -> next cycle state=IDLE, all strobes 0, state_leds=0. A following read completes normally.
6. Back-to-back read then write with resp_ready held low 4 cycles -> the write is not accepted until the response handshake completes.
